ysyx_22050550_scoreboard: RTL and testbench

- Register-hazard scoreboard sitting beside the IDU, directly upstream of the bypass/forwarding unit.
- Tracks the number of in-flight writes to each GPR, from IDU issue until WBU retire or squash.
- Raises a stall whenever an IDU source operand is still pending and the WBU-to-IDU forwarding path cannot supply it in the current cycle.
- Guarantees that the forwarding unit only ever forwards from the youngest writer of a register.

---
 rtl/ysyx_22050550_sb_pkg.sv | 15 +
 rtl/ysyx_22050550_sb_counter.sv | 42 ++++
 rtl/ysyx_22050550_scoreboard.sv | 94 +++++++++
 tb/tb_ysyx_22050550_scoreboard.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_sb_pkg.sv
// Shared constants for the register-hazard scoreboard.
// Covers GPR index width, tracked register count, default counter width and the x0 index.
package ysyx_22050550_sb_pkg;

  localparam int GPR_IDX_W = 5;
  localparam int SB_NREG   = 32;
  localparam int SB_CNT_W  = 2;

  localparam logic [GPR_IDX_W-1:0] X0_IDX = '0;

  function automatic logic is_x0(input logic [GPR_IDX_W-1:0] idx);
    return idx == X0_IDX;
  endfunction

endpackage

// File: rtl/ysyx_22050550_sb_counter.sv
// Per-register in-flight write counter.
// Takes one increment and up to three decrements per cycle; it clamps at 0 on underflow and saturates at max.
module ysyx_22050550_sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             uflow
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   sum;
  logic [CNT_W:0]   diff;

  always_comb begin
    sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
    diff  = sum - (CNT_W+1)'(dec);
    uflow = (CNT_W+1)'(dec) > sum;
    cnt_d = cnt_q;
    if (uflow) begin
      cnt_d = '0;
    end else if (diff[CNT_W]) begin
      cnt_d = '1;
    end else begin
      cnt_d = diff[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/ysyx_22050550_scoreboard.sv
// Register-hazard scoreboard: counts in-flight writes per GPR and stalls the IDU
// when a source is pending and the same-cycle WBU forward cannot cover it.
module ysyx_22050550_scoreboard
  import ysyx_22050550_sb_pkg::*;
#(
  parameter int NREG  = SB_NREG,
  parameter int CNT_W = SB_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io_issue_valid,
  input  logic [GPR_IDX_W-1:0] io_issue_rs1,
  input  logic                 io_issue_rs1_en,
  input  logic [GPR_IDX_W-1:0] io_issue_rs2,
  input  logic                 io_issue_rs2_en,
  input  logic [GPR_IDX_W-1:0] io_issue_rd,
  input  logic                 io_issue_wen,
  output logic                 io_issue_fire,
  output logic                 io_stall,
  input  logic                 io_wb_valid,
  input  logic [GPR_IDX_W-1:0] io_wb_waddr,
  input  logic                 io_kill0_valid,
  input  logic [GPR_IDX_W-1:0] io_kill0_waddr,
  input  logic                 io_kill1_valid,
  input  logic [GPR_IDX_W-1:0] io_kill1_waddr,
  output logic [NREG-1:0]      io_busy,
  output logic                 io_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt [NREG];
  logic [NREG-1:0]  inc_vec, wb_hit, k0_hit, k1_hit, uflow_vec;
  logic             rs1_haz, rs2_haz, struct_haz, stall_raw;
  logic             err_q, err_d;

  assign cnt[0]       = '0;
  assign inc_vec[0]   = 1'b0;
  assign wb_hit[0]    = 1'b0;
  assign k0_hit[0]    = 1'b0;
  assign k1_hit[0]    = 1'b0;
  assign uflow_vec[0] = 1'b0;

  // One-hot decode of every write/retire/squash port; x0 never decodes.
  for (genvar i = 1; i < NREG; i++) begin : g_reg
    assign wb_hit[i]  = io_wb_valid    && (io_wb_waddr    == GPR_IDX_W'(i));
    assign k0_hit[i]  = io_kill0_valid && (io_kill0_waddr == GPR_IDX_W'(i));
    assign k1_hit[i]  = io_kill1_valid && (io_kill1_waddr == GPR_IDX_W'(i));
    assign inc_vec[i] = io_issue_fire && io_issue_wen && (io_issue_rd == GPR_IDX_W'(i));

    ysyx_22050550_sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc_vec[i]),
      .dec   (2'({1'b0, wb_hit[i]}) + 2'({1'b0, k0_hit[i]}) + 2'({1'b0, k1_hit[i]})),
      .cnt   (cnt[i]),
      .uflow (uflow_vec[i])
    );
  end

  for (genvar i = 0; i < NREG; i++) begin : g_busy
    assign io_busy[i] = |cnt[i];
  end

  // A single pending writer that retires this cycle is covered by the WBU forward.
  always_comb begin
    rs1_haz = io_issue_rs1_en && !is_x0(io_issue_rs1) && (cnt[io_issue_rs1] != '0)
              && !((cnt[io_issue_rs1] == CNT_ONE) && wb_hit[io_issue_rs1]);
    rs2_haz = io_issue_rs2_en && !is_x0(io_issue_rs2) && (cnt[io_issue_rs2] != '0)
              && !((cnt[io_issue_rs2] == CNT_ONE) && wb_hit[io_issue_rs2]);
    struct_haz = io_issue_wen && !is_x0(io_issue_rd) && (cnt[io_issue_rd] == CNT_MAX)
                 && !(wb_hit[io_issue_rd] || k0_hit[io_issue_rd] || k1_hit[io_issue_rd]);
    stall_raw = io_issue_valid && (rs1_haz || rs2_haz || struct_haz);
  end

  assign io_stall      = !reset && stall_raw;
  assign io_issue_fire = !reset && io_issue_valid && !stall_raw;

  always_comb begin
    err_d = err_q || (|uflow_vec);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign io_err = err_q;

endmodule

// File: tb/tb_ysyx_22050550_scoreboard.sv
// Directed bench for the scoreboard with a counting model checked every negedge.
module tb_ysyx_22050550_scoreboard;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid, rs1_en, rs2_en, wen, wb_valid, k0_valid, k1_valid;
  logic [4:0]  rs1, rs2, rd, wb_waddr, k0_waddr, k1_waddr;
  logic        fire, stall, err;
  logic [31:0] busy;

  int n_vec = 0;
  int n_bad = 0;

  int mcnt [32];
  bit merr;

  always #5 clock = ~clock;

  ysyx_22050550_scoreboard dut (
    .clock          (clock),
    .reset          (reset),
    .io_issue_valid (valid),
    .io_issue_rs1   (rs1),
    .io_issue_rs1_en(rs1_en),
    .io_issue_rs2   (rs2),
    .io_issue_rs2_en(rs2_en),
    .io_issue_rd    (rd),
    .io_issue_wen   (wen),
    .io_issue_fire  (fire),
    .io_stall       (stall),
    .io_wb_valid    (wb_valid),
    .io_wb_waddr    (wb_waddr),
    .io_kill0_valid (k0_valid),
    .io_kill0_waddr (k0_waddr),
    .io_kill1_valid (k1_valid),
    .io_kill1_waddr (k1_waddr),
    .io_busy        (busy),
    .io_err         (err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: number of retirements/squashes hitting register r this cycle.
  function automatic int mdec(input int r);
    int d;
    d = 0;
    if (wb_valid && wb_waddr == r) d++;
    if (k0_valid && k0_waddr == r) d++;
    if (k1_valid && k1_waddr == r) d++;
    return d;
  endfunction

  function automatic bit mhaz(input int r, input bit en);
    if (!en || r == 0 || mcnt[r] == 0) return 1'b0;
    if (mcnt[r] == 1 && wb_valid && wb_waddr == r) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit mstall();
    bit s;
    s = (wen && rd != 0 && mcnt[rd] == 3 && mdec(int'(rd)) == 0);
    return valid && (mhaz(int'(rs1), rs1_en) || mhaz(int'(rs2), rs2_en) || s);
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mcnt[i] <= 0;
      merr <= 1'b0;
    end else begin
      int  nxt [32];
      bit  f, u;
      int  n;
      f = valid && !mstall();
      u = 1'b0;
      nxt[0] = 0;
      for (int i = 1; i < 32; i++) begin
        n = mcnt[i] + ((f && wen && rd == i) ? 1 : 0) - mdec(i);
        if (n < 0) begin
          n = 0;
          u = 1'b1;
        end
        if (n > 3) n = 3;
        nxt[i] = n;
      end
      mcnt <= nxt;
      merr <= merr | u;
    end
  end

  always @(negedge clock) begin
    logic [31:0] eb;
    if (reset) begin
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_fire", {63'd0, fire}, 64'd0);
      check("rst_busy", {32'd0, busy}, 64'd0);
    end else begin
      bit s;
      s = mstall();
      eb = '0;
      for (int i = 1; i < 32; i++) eb[i] = (mcnt[i] != 0);
      check("stall", {63'd0, stall}, {63'd0, s});
      check("fire", {63'd0, fire}, {63'd0, valid && !s});
      check("busy", {32'd0, busy}, {32'd0, eb});
      check("err", {63'd0, err}, {63'd0, merr});
    end
  end

  task automatic idle();
    valid = 0; rs1 = 0; rs1_en = 0; rs2 = 0; rs2_en = 0; rd = 0; wen = 0;
    wb_valid = 0; wb_waddr = 0; k0_valid = 0; k0_waddr = 0; k1_valid = 0; k1_waddr = 0;
  endtask

  task automatic iss(input int a1, input bit e1, input int a2, input bit e2, input int d, input bit w);
    valid = 1; rs1 = 5'(a1); rs1_en = e1; rs2 = 5'(a2); rs2_en = e2; rd = 5'(d); wen = w;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    reset = 1;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    #1;
    check("reset_busy", {32'd0, busy}, 64'd0);
    check("reset_err", {63'd0, err}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);

    // RAW on x5, released by same-cycle writeback
    iss(0, 0, 0, 0, 5, 1); #1;
    check("s1_issue_fire", {63'd0, fire}, 64'd1);
    tick(); iss(5, 1, 0, 0, 0, 0); #1;
    check("s1_raw_stall", {63'd0, stall}, 64'd1);
    check("s1_busy5", {63'd0, busy[5]}, 64'd1);
    tick(); #1;
    check("s1_still_stall", {63'd0, stall}, 64'd1);
    tick(); wb_valid = 1; wb_waddr = 5; #1;
    check("s1_fwd_nostall", {63'd0, stall}, 64'd0);
    check("s1_fwd_fire", {63'd0, fire}, 64'd1);
    tick(); idle(); #1;
    check("s1_busy5_clear", {63'd0, busy[5]}, 64'd0);

    // two writers to x7: first writeback is stale
    iss(0, 0, 0, 0, 7, 1);
    tick(); tick();
    iss(0, 0, 7, 1, 0, 0); wb_valid = 1; wb_waddr = 7; #1;
    check("s2_stale_stall", {63'd0, stall}, 64'd1);
    tick(); #1;
    check("s2_last_nostall", {63'd0, stall}, 64'd0);
    check("s2_last_fire", {63'd0, fire}, 64'd1);
    tick(); idle(); #1;
    check("s2_busy7_clear", {63'd0, busy[7]}, 64'd0);

    // saturate x9
    iss(0, 0, 0, 0, 9, 1);
    tick(); tick(); tick(); #1;
    check("s3_struct_stall", {63'd0, stall}, 64'd1);
    tick(); wb_valid = 1; wb_waddr = 9; #1;
    check("s3_net_nostall", {63'd0, stall}, 64'd0);
    check("s3_net_fire", {63'd0, fire}, 64'd1);
    tick(); idle(); #1;
    check("s3_busy9_kept", {63'd0, busy[9]}, 64'd1);
    wb_valid = 1; wb_waddr = 9;
    tick(); tick(); tick(); idle(); #1;
    check("s3_busy9_drained", {63'd0, busy[9]}, 64'd0);
    check("s3_no_err", {63'd0, err}, 64'd0);

    // double kill underflow on x4
    iss(0, 0, 0, 0, 4, 1);
    tick(); idle(); k0_valid = 1; k0_waddr = 4; k1_valid = 1; k1_waddr = 4;
    tick(); idle(); #1;
    check("s4_err_set", {63'd0, err}, 64'd1);
    check("s4_busy4_zero", {63'd0, busy[4]}, 64'd0);
    tick(); tick(); #1;
    check("s4_err_sticky", {63'd0, err}, 64'd1);
    reset = 1;
    tick(); reset = 0; #1;
    check("s4_err_cleared", {63'd0, err}, 64'd0);

    // x0 traffic is ignored
    iss(0, 1, 0, 1, 0, 1); wb_valid = 1; wb_waddr = 0; k0_valid = 1; k0_waddr = 0; #1;
    check("s5_x0_nostall", {63'd0, stall}, 64'd0);
    check("s5_x0_fire", {63'd0, fire}, 64'd1);
    tick(); idle(); #1;
    check("s5_x0_busy", {32'd0, busy}, 64'd0);
    check("s5_x0_err", {63'd0, err}, 64'd0);

    // async reset in the middle of a stall on x3
    iss(0, 0, 0, 0, 3, 1);
    tick(); tick();
    iss(3, 1, 0, 0, 0, 0); #1;
    check("s6_pre_stall", {63'd0, stall}, 64'd1);
    check("s6_pre_busy3", {63'd0, busy[3]}, 64'd1);
    #1 reset = 1;
    #1;
    check("s6_async_busy", {32'd0, busy}, 64'd0);
    check("s6_async_stall", {63'd0, stall}, 64'd0);
    check("s6_async_fire", {63'd0, fire}, 64'd0);
    @(posedge clock); #1 reset = 0; #1;
    check("s6_post_nostall", {63'd0, stall}, 64'd0);
    check("s6_post_fire", {63'd0, fire}, 64'd1);
    tick(); idle();
    tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
